// File: rtl/snake_pkg.sv
// Shared grid, body-length and segment definitions for the snake game logic.
package snake_pkg;

  localparam int GRID_W  = 40;
  localparam int GRID_H  = 30;
  localparam int X_W     = 6;
  localparam int Y_W     = 5;
  localparam int MAX_LEN = 32;
  localparam int IDX_W   = 5;
  localparam int LEN_W   = 6;
  localparam int SEG_W   = X_W + Y_W;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } seg_t;

  // Body length input may exceed the buffer depth; it is saturated at MAX_LEN.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l;
  endfunction

endpackage

// File: rtl/snake_hit_scan_if.sv
// Query request and result bundle between a requester and snake_hit_scan.
interface snake_hit_scan_if;
  import snake_pkg::*;

  logic             q_valid;
  logic             q_ready;
  logic [X_W-1:0]   q_x;
  logic [Y_W-1:0]   q_y;
  logic             q_skip_head;
  logic             r_valid;
  logic             r_hit;
  logic [IDX_W-1:0] r_index;

  modport master (
    output q_valid, q_x, q_y, q_skip_head,
    input  q_ready, r_valid, r_hit, r_index
  );

  modport slave (
    input  q_valid, q_x, q_y, q_skip_head,
    output q_ready, r_valid, r_hit, r_index
  );

endinterface

// File: rtl/snake_hit_scan.sv
// Walks the snake body ring buffer from the head and reports whether a grid
// cell is occupied, and by which segment offset first.
module snake_hit_scan
  import snake_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  snake_hit_scan_if.slave  bus,
  input  logic [LEN_W-1:0] len,
  input  logic [IDX_W-1:0] head_ptr,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [SEG_W-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t           state, nxt;
  logic [X_W-1:0]   qx;
  logic [Y_W-1:0]   qy;
  logic [LEN_W-1:0] len_r;
  logic [IDX_W-1:0] hptr;
  logic             start;
  logic [LEN_W-1:0] off;
  logic             cmp_valid;
  logic [IDX_W-1:0] cmp_off;
  logic             hit_r;
  logic [IDX_W-1:0] index_r;

  logic             accept;
  logic [LEN_W-1:0] len_c;
  logic             n_zero;
  logic             last_read;
  logic             match;
  seg_t             seg;

  assign seg       = seg_t'(rd_data);
  assign accept    = bus.q_valid && (state == IDLE);
  assign len_c     = clamp_len(len);
  assign n_zero    = (len_c <= {{(LEN_W-1){1'b0}}, bus.q_skip_head});
  assign last_read = (off == len_r - LEN_W'(1));
  // Data comes back one cycle after its read; only compare while a scan owns it.
  assign match     = cmp_valid && ((state == SCAN) || (state == DRAIN)) &&
                     (seg.x == qx) && (seg.y == qy);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt         = state;
    bus.q_ready = 1'b0;
    bus.r_valid = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    unique case (state)
      IDLE: begin
        bus.q_ready = 1'b1;
        if (accept) nxt = n_zero ? DONE : SCAN;
      end
      SCAN: begin
        // A hit stops the walk in the same cycle, so no read is wasted.
        if (match) begin
          nxt = DONE;
        end else begin
          rd_en   = 1'b1;
          rd_addr = hptr + off[IDX_W-1:0];
          if (last_read) nxt = DRAIN;
        end
      end
      DRAIN: nxt = DONE;
      DONE: begin
        bus.r_valid = 1'b1;
        nxt         = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qx        <= '0;
      qy        <= '0;
      len_r     <= '0;
      hptr      <= '0;
      start     <= 1'b0;
      off       <= '0;
      cmp_valid <= 1'b0;
      cmp_off   <= '0;
      hit_r     <= 1'b0;
      index_r   <= '0;
    end else begin
      cmp_valid <= rd_en;
      cmp_off   <= off[IDX_W-1:0];
      if (accept) begin
        qx      <= bus.q_x;
        qy      <= bus.q_y;
        len_r   <= len_c;
        hptr    <= head_ptr;
        start   <= bus.q_skip_head;
        off     <= {{(LEN_W-1){1'b0}}, bus.q_skip_head};
        hit_r   <= 1'b0;
        index_r <= '0;
      end else if (rd_en) begin
        off <= off + LEN_W'(1);
      end
      if (match) begin
        hit_r   <= 1'b1;
        index_r <= cmp_off;
      end
    end
  end

  assign bus.r_hit   = hit_r;
  assign bus.r_index = index_r;

endmodule

// File: tb/tb_snake_hit_scan.sv
// Randomized and directed checks of snake_hit_scan against a body-RAM model
// and a list-walking reference of the occupancy query.
module tb_snake_hit_scan;
  import snake_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [LEN_W-1:0] len = '0;
  logic [IDX_W-1:0] head_ptr = '0;
  logic             rd_en;
  logic [IDX_W-1:0] rd_addr;
  logic [SEG_W-1:0] rd_data = '0;

  logic [SEG_W-1:0] mem [MAX_LEN];
  logic [IDX_W-1:0] obs_addr [$];
  logic [IDX_W-1:0] exp_addr [$];

  int total = 0;
  int bad   = 0;

  snake_hit_scan_if bus ();

  snake_hit_scan dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .len      (len),
    .head_ptr (head_ptr),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  function automatic string q2s(input logic [IDX_W-1:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  function automatic logic [13:0] out_snap();
    return {bus.q_ready, rd_en, rd_addr, bus.r_valid, bus.r_hit, bus.r_index};
  endfunction

  // Reference: walk the body list from the head and stop at the first matching cell.
  task automatic model(input int x, input int y, input int skip, input int l, input int hp,
                       output int lat, output logic hit, output logic [IDX_W-1:0] idx);
    int lc;
    lc  = (l > MAX_LEN) ? MAX_LEN : l;
    hit = 1'b0;
    idx = '0;
    exp_addr.delete();
    if (lc <= skip) begin
      lat = 1;
    end else begin
      for (int i = skip; i < lc; i++) begin
        int a;
        a = (hp + i) % MAX_LEN;
        exp_addr.push_back(IDX_W'(a));
        if (int'(mem[a][10:5]) == x && int'(mem[a][4:0]) == y) begin
          hit = 1'b1;
          idx = IDX_W'(i);
          break;
        end
      end
      lat = hit ? (int'(idx) - skip + 3) : (lc - skip + 2);
    end
  endtask

  task automatic fill_body(input logic [SEG_W-1:0] v);
    for (int i = 0; i < MAX_LEN; i++) mem[i] = v;
  endtask

  task automatic run_query(input int x, input int y, input int skip, input int l, input int hp,
                           input int busy_at, input int rst_at,
                           output int lat, output logic hit, output logic [IDX_W-1:0] idx,
                           output logic ready_busy, output logic [13:0] snap);
    obs_addr.delete();
    lat        = -1;
    hit        = 1'b0;
    idx        = '0;
    ready_busy = 1'b1;
    snap       = '0;
    @(negedge clk);
    bus.q_valid     = 1'b1;
    bus.q_x         = X_W'(x);
    bus.q_y         = Y_W'(y);
    bus.q_skip_head = skip[0];
    len             = LEN_W'(l);
    head_ptr        = IDX_W'(hp);
    @(posedge clk);
    #1;
    bus.q_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      len      = LEN_W'($urandom);
      head_ptr = IDX_W'($urandom);
      if (rd_en) obs_addr.push_back(rd_addr);
      if (bus.r_valid) begin
        lat = c;
        hit = bus.r_hit;
        idx = bus.r_index;
        break;
      end
      if (c == busy_at) begin
        ready_busy      = bus.q_ready;
        bus.q_valid     = 1'b1;
        bus.q_x         = X_W'($urandom_range(0, GRID_W - 1));
        bus.q_y         = Y_W'($urandom_range(0, GRID_H - 1));
        bus.q_skip_head = 1'b0;
      end else begin
        bus.q_valid = 1'b0;
      end
      if (rst_at > 0) begin
        if (c == rst_at) rst = 1'b1;
        if (c == rst_at + 1) begin
          snap = out_snap();
          rst  = 1'b0;
        end
        if (c == rst_at + 8) break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (out_snap() !== 14'b1_0_00000_0_0_00000) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b want=%b", out_snap(), 14'b1_0_00000_0_0_00000);
    end
    rst = 1'b0;
  endtask

  task automatic test_miss();
    int lat; logic hit; logic [IDX_W-1:0] idx; logic rb; logic [13:0] sn;
    fill_body({6'd63, 5'd31});
    mem[0] = {6'd10, 5'd5}; mem[1] = {6'd9, 5'd5};
    mem[2] = {6'd8, 5'd5};  mem[3] = {6'd7, 5'd5};
    run_query(3, 3, 0, 4, 0, 0, 0, lat, hit, idx, rb, sn);
    total++;
    if (q2s(obs_addr) != "0 1 2 3 ") begin
      bad++; $display("[TB] FAIL miss_addrs got=%s want=0 1 2 3", q2s(obs_addr));
    end
    total++;
    if (lat != 6 || hit !== 1'b0 || idx !== 5'd0) begin
      bad++; $display("[TB] FAIL miss_result got lat=%0d hit=%b idx=%0d want lat=6 hit=0 idx=0", lat, hit, idx);
    end
  endtask

  task automatic test_head_skip();
    int lat; logic hit; logic [IDX_W-1:0] idx; logic rb; logic [13:0] sn;
    run_query(10, 5, 0, 4, 0, 0, 0, lat, hit, idx, rb, sn);
    total++;
    if (lat != 3 || hit !== 1'b1 || idx !== 5'd0 || q2s(obs_addr) != "0 ") begin
      bad++; $display("[TB] FAIL head_hit got lat=%0d hit=%b idx=%0d addrs=%s want lat=3 hit=1 idx=0 addrs=0",
                      lat, hit, idx, q2s(obs_addr));
    end
    run_query(10, 5, 1, 4, 0, 0, 0, lat, hit, idx, rb, sn);
    total++;
    if (lat != 5 || hit !== 1'b0 || idx !== 5'd0 || q2s(obs_addr) != "1 2 3 ") begin
      bad++; $display("[TB] FAIL head_skip got lat=%0d hit=%b idx=%0d addrs=%s want lat=5 hit=0 idx=0 addrs=1 2 3",
                      lat, hit, idx, q2s(obs_addr));
    end
  endtask

  task automatic test_wrap();
    int lat; logic hit; logic [IDX_W-1:0] idx; logic rb; logic [13:0] sn;
    fill_body({6'd1, 5'd1});
    mem[1] = {6'd20, 5'd12};
    run_query(20, 12, 0, 5, 30, 0, 0, lat, hit, idx, rb, sn);
    total++;
    if (q2s(obs_addr) != "30 31 0 1 ") begin
      bad++; $display("[TB] FAIL wrap_addrs got=%s want=30 31 0 1", q2s(obs_addr));
    end
    total++;
    if (lat != 6 || hit !== 1'b1 || idx !== 5'd3) begin
      bad++; $display("[TB] FAIL wrap_result got lat=%0d hit=%b idx=%0d want lat=6 hit=1 idx=3", lat, hit, idx);
    end
  endtask

  task automatic test_degenerate();
    int lat; logic hit; logic [IDX_W-1:0] idx; logic rb; logic [13:0] sn;
    fill_body({6'd5, 5'd5});
    run_query(5, 5, 1, 1, 7, 0, 0, lat, hit, idx, rb, sn);
    total++;
    if (lat != 1 || hit !== 1'b0 || obs_addr.size() != 0) begin
      bad++; $display("[TB] FAIL len1_skip got lat=%0d hit=%b reads=%0d want lat=1 hit=0 reads=0", lat, hit, obs_addr.size());
    end
    run_query(5, 5, 0, 0, 7, 0, 0, lat, hit, idx, rb, sn);
    total++;
    if (lat != 1 || hit !== 1'b0 || obs_addr.size() != 0) begin
      bad++; $display("[TB] FAIL len0 got lat=%0d hit=%b reads=%0d want lat=1 hit=0 reads=0", lat, hit, obs_addr.size());
    end
    run_query(0, 0, 0, 40, 9, 0, 0, lat, hit, idx, rb, sn);
    total++;
    if (lat != 34 || hit !== 1'b0 || obs_addr.size() != 32) begin
      bad++; $display("[TB] FAIL len40 got lat=%0d hit=%b reads=%0d want lat=34 hit=0 reads=32", lat, hit, obs_addr.size());
    end
  endtask

  task automatic test_busy();
    int lat; logic hit; logic [IDX_W-1:0] idx; logic rb; logic [13:0] sn;
    fill_body({6'd2, 5'd2});
    run_query(30, 20, 0, 10, 4, 2, 0, lat, hit, idx, rb, sn);
    total++;
    if (rb !== 1'b0) begin
      bad++; $display("[TB] FAIL busy_ready got=%b want=0", rb);
    end
    total++;
    if (lat != 12 || hit !== 1'b0 || obs_addr.size() != 10) begin
      bad++; $display("[TB] FAIL busy_result got lat=%0d hit=%b reads=%0d want lat=12 hit=0 reads=10", lat, hit, obs_addr.size());
    end
    repeat (3) @(negedge clk);
    total++;
    if (rd_en !== 1'b0 || bus.q_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL busy_not_queued got rd_en=%b q_ready=%b want rd_en=0 q_ready=1", rd_en, bus.q_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat; logic hit; logic [IDX_W-1:0] idx; logic rb; logic [13:0] sn;
    fill_body({6'd1, 5'd1});
    mem[2] = {6'd5, 5'd5};
    run_query(5, 5, 0, 8, 0, 0, 3, lat, hit, idx, rb, sn);
    total++;
    if (sn !== 14'b1_0_00000_0_0_00000) begin
      bad++; $display("[TB] FAIL midscan_reset got=%b want=%b", sn, 14'b1_0_00000_0_0_00000);
    end
    total++;
    if (lat != -1 || bus.r_hit !== 1'b0 || bus.r_index !== 5'd0) begin
      bad++; $display("[TB] FAIL stale_data got lat=%0d r_hit=%b r_index=%0d want lat=-1 r_hit=0 r_index=0",
                      lat, bus.r_hit, bus.r_index);
    end
    run_query(5, 5, 0, 8, 0, 0, 0, lat, hit, idx, rb, sn);
    total++;
    if (lat != 5 || hit !== 1'b1 || idx !== 5'd2) begin
      bad++; $display("[TB] FAIL after_reset got lat=%0d hit=%b idx=%0d want lat=5 hit=1 idx=2", lat, hit, idx);
    end
  endtask

  task automatic test_random();
    int lat, elat, x, y, skip, l, hp;
    logic hit, ehit, rb;
    logic [IDX_W-1:0] idx, eidx;
    logic [13:0] sn;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < MAX_LEN; i++)
        mem[i] = {X_W'($urandom_range(0, GRID_W - 1)), Y_W'($urandom_range(0, GRID_H - 1))};
      l    = $urandom_range(0, 40);
      hp   = $urandom_range(0, MAX_LEN - 1);
      skip = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        int a;
        a = $urandom_range(0, MAX_LEN - 1);
        x = int'(mem[a][10:5]);
        y = int'(mem[a][4:0]);
      end else begin
        x = $urandom_range(0, GRID_W - 1);
        y = $urandom_range(0, GRID_H - 1);
      end
      model(x, y, skip, l, hp, elat, ehit, eidx);
      run_query(x, y, skip, l, hp, 0, 0, lat, hit, idx, rb, sn);
      total++;
      if (lat != elat || hit !== ehit || idx !== eidx || q2s(obs_addr) != q2s(exp_addr)) begin
        bad++; $display("[TB] FAIL random_%0d got lat=%0d hit=%b idx=%0d addrs=%s want lat=%0d hit=%b idx=%0d addrs=%s",
                        n, lat, hit, idx, q2s(obs_addr), elat, ehit, eidx, q2s(exp_addr));
      end
      repeat (2) @(negedge clk);
      total++;
      if (bus.r_hit !== ehit || bus.r_index !== eidx) begin
        bad++; $display("[TB] FAIL hold_%0d got hit=%b idx=%0d want hit=%b idx=%0d", n, bus.r_hit, bus.r_index, ehit, eidx);
      end
    end
  endtask

  initial begin
    bus.q_valid     = 1'b0;
    bus.q_x         = '0;
    bus.q_y         = '0;
    bus.q_skip_head = 1'b0;
    fill_body('0);
    test_reset();
    test_miss();
    test_head_skip();
    test_wrap();
    test_degenerate();
    test_busy();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_hit_scan.md
SNAKE_HIT_SCAN -- requirements
Module: snake_hit_scan

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 q_valid  input  1  query request.
REQ-005 q_ready  output  1  block idle; query accepted when q_valid && q_ready.
REQ-006 q_x  input  6  query grid column, 0..39.
REQ-007 q_y  input  5  query grid row, 0..29.
REQ-008 q_skip_head  input  1  exclude segment 0 (the head), used for self-collision checks.
REQ-009 len  input  6  current body length, 0..32.
REQ-010 head_ptr  input  5  circular-buffer index of the head segment.
REQ-011 rd_en  output  1  body RAM read strobe.
REQ-012 rd_addr  output  5  body RAM read address.
REQ-013 rd_data  input  11  segment {x[10:5], y[4:0]}, valid one cycle after rd_en.
REQ-014 r_valid  output  1  one-cycle result strobe.
REQ-015 r_hit  output  1  query cell is occupied by a scanned segment.
REQ-016 r_index  output  5  segment offset from the head of the first hit; 0 when there is no hit.

Function
REQ-017 Accept, in IDLE only: latch q_x, q_y, len (values above 32 clamped to 32), head_ptr and start = q_skip_head; N = len - start, floored at 0.
REQ-018 FSM states SHALL be IDLE, SCAN, DRAIN and DONE; q_ready SHALL be 1 only in IDLE.
REQ-019 Transition IDLE->SCAN on accept with N>0; IDLE->DONE on accept with N=0 (r_hit=0).
REQ-020 SCAN, one read per cycle: offset i = start..len-1; rd_addr = (head_ptr + i) mod 32 (5-bit wrap); rd_en=1.
REQ-021 Each returned segment SHALL be compared in the cycle after its read; a match is x==q_x && y==q_y.
REQ-022 On a match, the next state SHALL be DONE; r_hit SHALL be set to 1 and r_index to the offset i of that read; no further reads SHALL be issued after the match cycle.
REQ-023 After the last read without a match: SCAN->DRAIN; DRAIN compares the final data; DRAIN->DONE.
REQ-024 Latency from accept cycle T: no hit gives r_valid at T+N+2; hit at offset k gives r_valid at T+(k-start)+3; N=0 gives r_valid at T+1.
REQ-025 DONE SHALL last one cycle, with r_valid=1, then go to IDLE.
REQ-026 r_hit and r_index SHALL hold until the next accept, which SHALL clear them.
REQ-027 q_valid while busy SHALL be ignored, with no queuing.
REQ-028 len and head_ptr changing during a scan SHALL NOT affect the scan in progress.
REQ-029 rd_en SHALL be 0 in IDLE, DRAIN and DONE.

Reset
REQ-030 rst SHALL force IDLE in the next cycle, including during a scan.
REQ-031 Reset values: q_ready=1, rd_en=0, rd_addr=0, r_valid=0, r_hit=0, r_index=0; all latched query registers 0.
REQ-032 Read data returning after a reset SHALL be discarded.

Structure
REQ-033 Shared package snake_pkg SHALL hold GRID_W=40, GRID_H=30, X_W=6, Y_W=5, MAX_LEN=32, IDX_W=5, and the segment packing {x,y} with SEG_W=11.
REQ-034 The FSM state encoding SHALL be local to the module.
REQ-035 No sub-module; a single module of about 150-250 lines.

Verification
REQ-036 Bench SHALL model the body RAM with 1-cycle read latency and check every rd_addr.
REQ-037 Miss scan: len=4, head_ptr=0, segments (10,5),(9,5),(8,5),(7,5), query (3,3), skip=0 -> reads at addresses 0..3, r_valid at T+6, r_hit=0, r_index=0.
REQ-038 Head hit with skip: same body, query (10,5), skip=0 -> r_valid at T+3, r_hit=1, r_index=0; with skip=1 -> reads at addresses 1..3, r_hit=0, r_valid at T+5.
REQ-039 Wrap-around: head_ptr=30, len=5, segment at address 1 = (20,12), query (20,12) -> rd_addr sequence 30,31,0,1; r_hit=1, r_index=3.
REQ-040 Degenerate: len=1 with skip=1, and len=0 -> no rd_en, r_valid at T+1, r_hit=0; len=40 -> exactly 32 reads.
REQ-041 Busy and reset: second q_valid during a scan -> ignored, q_ready=0; rst asserted at the 3rd scan cycle -> next cycle IDLE, all outputs at reset values, no r_valid.
